// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch bundler and its lane store.
//   LANES_DEFAULT : default bundle width (matches the decode register)
//   NOP_INSTR     : padding word used for lanes below an aligned redirect target
//   SLOT_W        : lane-index width for the default bundle width
//   fetch_state_t : controller states
package fetch_pkg;

  localparam int unsigned LANES_DEFAULT = 8;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam int unsigned SLOT_W        = $clog2(LANES_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_lane_store.sv
// LANES x (instruction, pc) register array feeding the bundle outputs.
// Ports:
//   clk        : clock
//   clr        : synchronous bulk clear of every lane (highest priority)
//   pad        : load lanes 0..pad_k-1 with NOP and PCs pad_base+4i
//   pad_k      : number of lanes to pad
//   pad_base   : PC of lane 0 when padding
//   we         : write wr_instr/wr_pc into lane 'slot'
//   slot       : lane index for we
//   wr_instr   : instruction word to store
//   wr_pc      : PC of that word
//   instr_bus  : lane i instruction at [32i+31:32i]
//   pc_bus     : lane i PC, same packing
module fetch_lane_store
  import fetch_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       pad,
  input  logic [$clog2(LANES)-1:0]   pad_k,
  input  logic [31:0]                pad_base,
  input  logic                       we,
  input  logic [$clog2(LANES)-1:0]   slot,
  input  logic [31:0]                wr_instr,
  input  logic [31:0]                wr_pc,
  output logic [LANES*32-1:0]        instr_bus,
  output logic [LANES*32-1:0]        pc_bus
);

  localparam int unsigned SW = $clog2(LANES);

  logic [31:0] instr_q [LANES];
  logic [31:0] pc_q    [LANES];

  // Lane storage: clear beats pad beats single-lane write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(LANES); i++) begin
        instr_q[i] <= 32'h0;
        pc_q[i]    <= 32'h0;
      end
    end else if (pad) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (SW'(i) < pad_k) begin
          instr_q[i] <= NOP_INSTR;
          pc_q[i]    <= pad_base + 32'(4 * i);
        end
      end
    end else if (we) begin
      instr_q[slot] <= wr_instr;
      pc_q[slot]    <= wr_pc;
    end
  end

  // Flatten the arrays onto the output buses.
  for (genvar g = 0; g < int'(LANES); g++) begin : g_flat
    assign instr_bus[32*g +: 32] = instr_q[g];
    assign pc_bus[32*g +: 32]    = pc_q[g];
  end

endmodule

// File: rtl/fetch_bundler.sv
// Fetch-side producer: pulls one instruction word per cycle and packs LANES
// consecutive words with their PCs into a bundle offered to decode via
// valid/ready. A redirect discards in-flight work and restarts at the target.
// Optional feature macro: FETCH_BUNDLER_ALIGN_EN (pad lanes below the redirect
// target with NOPs so lane i always holds a PC whose index bits equal i).
// Ports:
//   clk, CLRn                : clock, synchronous active-low reset
//   fetch_en                 : permits instruction-memory requests
//   redirect, redirect_pc    : one-cycle redirect pulse and its target
//   imem_req, imem_addr      : combinational word request and address
//   imem_data, imem_valid    : same-cycle response, low valid = wait state
//   InstrF_bus, PC_bus       : registered bundle contents
//   bundle_valid             : registered bundle-valid
//   bundle_ready             : decode accepts this cycle
module fetch_bundler
  import fetch_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 CLRn,
  input  logic                 fetch_en,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  input  logic                 imem_valid,
  output logic [LANES*32-1:0]  InstrF_bus,
  output logic [LANES*32-1:0]  PC_bus,
  output logic                 bundle_valid,
  input  logic                 bundle_ready
);

  localparam int unsigned SW = $clog2(LANES);
  localparam logic [SW-1:0] LAST_SLOT = SW'(LANES - 1);

  fetch_state_t   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic           we;
  logic           pad;
  logic [SW-1:0]  pad_k;
  logic [31:0]    pad_base;

  // Request is combinational so a word can be accepted in the same cycle.
  always_comb begin
    imem_req  = (state_q == FILL) && fetch_en;
    imem_addr = fetch_pc_q;
  end

  // Next-state, fetch pointer and lane-store controls.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    slot_d     = slot_q;
    we         = 1'b0;
    pad        = 1'b0;
    pad_k      = '0;
    pad_base   = 32'h0;

    if (redirect) begin
      // Any word returned this cycle is dropped; partial/held bundle discarded.
      fetch_pc_d = redirect_pc & ~32'h3;
      slot_d     = '0;
      state_d    = fetch_en ? FILL : IDLE;
`ifdef FETCH_BUNDLER_ALIGN_EN
      slot_d     = redirect_pc[SW+1:2];
      pad        = 1'b1;
      pad_k      = redirect_pc[SW+1:2];
      pad_base   = redirect_pc & ~32'(LANES * 4 - 1);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_en) state_d = FILL;
        end
        FILL: begin
          if (imem_req && imem_valid) begin
            we         = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (slot_q == LAST_SLOT) begin
              slot_d  = '0;
              state_d = HOLD;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        HOLD: begin
          if (bundle_ready) state_d = FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!CLRn) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      slot_q       <= '0;
      bundle_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      slot_q       <= slot_d;
      bundle_valid <= (state_d == HOLD);
    end
  end

  fetch_lane_store #(
    .LANES (LANES)
  ) u_store (
    .clk       (clk),
    .clr       (!CLRn),
    .pad       (pad),
    .pad_k     (pad_k),
    .pad_base  (pad_base),
    .we        (we),
    .slot      (slot_q),
    .wr_instr  (imem_data),
    .wr_pc     (fetch_pc_q),
    .instr_bus (InstrF_bus),
    .pc_bus    (PC_bus)
  );

endmodule
